jump_controller: RTL and testbench

Resolves taken control-flow requests from the execute stage into the PC redirect interface. It takes a jump request (type, PC of the jump instruction, operand), computes the target per `jump_type_t`, and presents `jumpEnabled`/`jumpValue` to the program counter. It holds the redirect until the PC actually consumes it on a non-stalled edge, then pulses `flush` to squash wrong-path fetch. Sits between the execute stage and the program counter.

---
 rtl/jump_controller_pkg.sv | 31 +++
 rtl/jump_controller_target_calc.sv | 32 +++
 rtl/jump_controller.sv | 104 ++++++++++
 tb/tb_jump_controller.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_controller_pkg.sv
// jump_controller_pkg
// Types and constants shared by the jump controller and its target calculator.
//   int_t                  : 32-bit machine word
//   jump_type_t            : NEAR / FAR / RELATIVE; encoding 2'b11 is illegal
//   jump_state_t           : controller FSM states
//   JUMP_NEAR_MASK_DEFAULT : PC region bits kept from PC+4 for NEAR jumps
//   jump_type_legal()      : true for the three defined jump encodings
package jump_controller_pkg;

    typedef logic [31:0] int_t;

    typedef enum logic [1:0] {
        JUMP_NEAR     = 2'b00,
        JUMP_FAR      = 2'b01,
        JUMP_RELATIVE = 2'b10
    } jump_type_t;

    // ST_SLOT is only reachable when JUMP_DELAY_SLOT_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SLOT  = 2'b01,
        ST_ISSUE = 2'b10
    } jump_state_t;

    localparam int_t JUMP_NEAR_MASK_DEFAULT = 32'hF000_0000;

    function automatic logic jump_type_legal(input logic [1:0] jump_type);
        return (jump_type != 2'b11);
    endfunction

endpackage

// File: rtl/jump_controller_target_calc.sv
// jump_target_calc
// Combinational jump target calculation. All arithmetic wraps modulo 2^32.
//   jump_type : 2-bit jump_type_t encoding (2'b11 yields 0; caller rejects it)
//   pc        : address of the jump instruction
//   operand   : NEAR word index / FAR absolute target / RELATIVE word offset
//   target    : computed redirect address
module jump_target_calc
    import jump_controller_pkg::*;
#(
    parameter int_t NEAR_MASK = JUMP_NEAR_MASK_DEFAULT
) (
    input  logic [1:0]  jump_type,
    input  logic [31:0] pc,
    input  logic [31:0] operand,
    output logic [31:0] target
);

    int_t pc4;

    always_comb begin
        pc4    = pc + 32'd4;
        target = '0;
        case (jump_type)
            JUMP_NEAR:     target = (pc4 & NEAR_MASK) | {4'b0000, operand[25:0], 2'b00};
            JUMP_FAR:      target = operand;
            // Word offset shifted left by two; the top two operand bits fall off.
            JUMP_RELATIVE: target = pc4 + {operand[29:0], 2'b00};
            default:       target = '0;
        endcase
    end

endmodule

// File: rtl/jump_controller.sv
// jump_controller
// Turns taken jump requests from execute into a held PC redirect, then flushes
// the wrong-path fetch on the cycle the PC consumes it.
// Optional feature: define JUMP_DELAY_SLOT_EN to add a SLOT state so the
// instruction after the jump (the delay slot) is fetched before the redirect.
// Ports:
//   clock, reset   : clock; asynchronous active-high reset
//   stall          : PC stall; the PC consumes jumpValue only when stall=0
//   requestValid/Taken/Type/Pc/Operand : jump request from execute
//   requestReady   : high in IDLE only
//   jumpEnabled    : redirect valid (ISSUE state)
//   jumpValue      : registered redirect target
//   flush          : high during the consuming cycle (ISSUE && !stall)
//   badType        : sticky, set by an accepted taken request with type 2'b11
module jump_controller
    import jump_controller_pkg::*;
#(
    parameter int_t NEAR_MASK = JUMP_NEAR_MASK_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        requestValid,
    input  logic        requestTaken,
    input  logic [1:0]  requestType,
    input  logic [31:0] requestPc,
    input  logic [31:0] requestOperand,
    output logic        requestReady,
    output logic        jumpEnabled,
    output logic [31:0] jumpValue,
    output logic        flush,
    output logic        badType
);

    jump_state_t state_q, state_d;
    int_t        jump_value_q, jump_value_d;
    logic        bad_type_q, bad_type_d;
    int_t        target;

    jump_target_calc #(
        .NEAR_MASK (NEAR_MASK)
    ) u_target_calc (
        .jump_type (requestType),
        .pc        (requestPc),
        .operand   (requestOperand),
        .target    (target)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            jump_value_q <= '0;
            bad_type_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            jump_value_q <= jump_value_d;
            bad_type_q   <= bad_type_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        jump_value_d = jump_value_q;
        bad_type_d   = bad_type_q;
        case (state_q)
            ST_IDLE: begin
                // Not-taken requests are accepted but leave no trace.
                if (requestValid && requestTaken) begin
                    if (jump_type_legal(requestType)) begin
                        jump_value_d = target;
`ifdef JUMP_DELAY_SLOT_EN
                        state_d      = ST_SLOT;
`else
                        state_d      = ST_ISSUE;
`endif
                    end else begin
                        bad_type_d = 1'b1;
                    end
                end
            end
`ifdef JUMP_DELAY_SLOT_EN
            // Let the delay-slot fetch complete on an unstalled edge first.
            ST_SLOT: begin
                if (!stall) begin
                    state_d = ST_ISSUE;
                end
            end
`endif
            ST_ISSUE: begin
                if (!stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign requestReady = (state_q == ST_IDLE);
    assign jumpEnabled  = (state_q == ST_ISSUE);
    assign flush        = (state_q == ST_ISSUE) && !stall;
    assign jumpValue    = jump_value_q;
    assign badType      = bad_type_q;

endmodule

// File: tb/tb_jump_controller.sv
// Directed testbench for jump_controller. Inputs are driven and outputs
// sampled 1 ns after the rising edge.
module tb_jump_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        requestValid;
    logic        requestTaken;
    logic [1:0]  requestType;
    logic [31:0] requestPc;
    logic [31:0] requestOperand;
    logic        requestReady;
    logic        jumpEnabled;
    logic [31:0] jumpValue;
    logic        flush;
    logic        badType;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [1:0] T_NEAR = 2'b00;
    localparam logic [1:0] T_FAR  = 2'b01;
    localparam logic [1:0] T_REL  = 2'b10;
    localparam logic [1:0] T_BAD  = 2'b11;

    jump_controller dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .requestValid   (requestValid),
        .requestTaken   (requestTaken),
        .requestType    (requestType),
        .requestPc      (requestPc),
        .requestOperand (requestOperand),
        .requestReady   (requestReady),
        .jumpEnabled    (jumpEnabled),
        .jumpValue      (jumpValue),
        .flush          (flush),
        .badType        (badType)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request for one edge, then withdraw it.
    task automatic send(input logic [1:0] t, input logic [31:0] pc,
                        input logic [31:0] op, input logic taken);
        requestValid   = 1'b1;
        requestTaken   = taken;
        requestType    = t;
        requestPc      = pc;
        requestOperand = op;
        step();
        requestValid   = 1'b0;
    endtask

    // After acceptance, advance through the delay slot when it exists.
    task automatic wait_issue();
`ifdef JUMP_DELAY_SLOT_EN
        step();
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0;
        requestValid = 1'b0;
        requestTaken = 1'b0;
        requestType = 2'b00;
        requestPc = '0;
        requestOperand = '0;
        step();
        step();
        tests_run++;
        if ({jumpEnabled, jumpValue, flush, badType, requestReady} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset: en=%b val=%h flush=%b bad=%b rdy=%b, required 0 00000000 0 0 1",
                     jumpEnabled, jumpValue, flush, badType, requestReady);
        end
        @(negedge clock);
        reset = 1'b0;
        step();
        $display("[TB] reset done");
    endtask

    task automatic test_relative();
        send(T_REL, 32'h0000_3000, 32'hFFFF_FFFF, 1'b1);
        tests_run++;
        if (requestReady !== 1'b0) begin
            tests_failed++;
            $display("FAIL rel_ready_low: got %b required 0", requestReady);
        end
        wait_issue();
        tests_run++;
        if ({jumpEnabled, jumpValue, flush} !== {1'b1, 32'h0000_3000, 1'b1}) begin
            tests_failed++;
            $display("FAIL rel_issue: en=%b val=%h flush=%b, required 1 00003000 1",
                     jumpEnabled, jumpValue, flush);
        end
        step();
        tests_run++;
        if ({jumpEnabled, flush, requestReady} !== 3'b001) begin
            tests_failed++;
            $display("FAIL rel_done: en=%b flush=%b rdy=%b, required 0 0 1",
                     jumpEnabled, flush, requestReady);
        end
        $display("[TB] relative pc=00003000 op=ffffffff val=%h", jumpValue);
    endtask

    task automatic test_targets();
        logic [1:0]  types [3] = '{T_NEAR, T_FAR, T_REL};
        logic [31:0] pcs   [3] = '{32'h4000_1000, 32'h1234_5678, 32'hFFFF_FFF8};
        logic [31:0] ops   [3] = '{32'h0000_0400, 32'hBFC0_0000, 32'h0000_0002};
        logic [31:0] exps  [3] = '{32'h4000_1000, 32'hBFC0_0000, 32'h0000_0004};
        for (int i = 0; i < 3; i++) begin
            send(types[i], pcs[i], ops[i], 1'b1);
            wait_issue();
            tests_run++;
            if ({jumpEnabled, jumpValue} !== {1'b1, exps[i]}) begin
                tests_failed++;
                $display("FAIL target_%0d: en=%b val=%h, required 1 %h", i, jumpEnabled, jumpValue, exps[i]);
            end
            $display("[TB] target type=%0d pc=%h op=%h val=%h", types[i], pcs[i], ops[i], jumpValue);
            step();
        end
    endtask

    task automatic test_stall();
        send(T_FAR, 32'h0000_0100, 32'hBFC0_0000, 1'b1);
        wait_issue();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if ({jumpEnabled, jumpValue, flush, requestReady} !== {1'b1, 32'hBFC0_0000, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d: en=%b val=%h flush=%b rdy=%b, required 1 bfc00000 0 0",
                         i, jumpEnabled, jumpValue, flush, requestReady);
            end
            step();
        end
        stall = 1'b0;
        #1;
        tests_run++;
        if ({jumpEnabled, jumpValue, flush} !== {1'b1, 32'hBFC0_0000, 1'b1}) begin
            tests_failed++;
            $display("FAIL stall_release: en=%b val=%h flush=%b, required 1 bfc00000 1",
                     jumpEnabled, jumpValue, flush);
        end
        step();
        tests_run++;
        if ({jumpEnabled, requestReady} !== 2'b01) begin
            tests_failed++;
            $display("FAIL stall_done: en=%b rdy=%b, required 0 1", jumpEnabled, requestReady);
        end
        $display("[TB] stall 3 cycles val=bfc00000");
    endtask

    // A request held by upstream while not ready must not overwrite the target.
    task automatic test_hold_while_busy();
        send(T_FAR, 32'h0, 32'h1111_1110, 1'b1);
        requestValid   = 1'b1;
        requestOperand = 32'h2222_2220;
        wait_issue();
        stall = 1'b1;
        step();
        tests_run++;
        if ({jumpEnabled, jumpValue} !== {1'b1, 32'h1111_1110}) begin
            tests_failed++;
            $display("FAIL hold_busy: en=%b val=%h, required 1 11111110", jumpEnabled, jumpValue);
        end
        requestValid = 1'b0;
        stall = 1'b0;
        step();
        $display("[TB] hold while busy val=%h", jumpValue);
    endtask

    task automatic test_not_taken();
        send(T_REL, 32'h0000_5000, 32'h0000_0010, 1'b0);
        tests_run++;
        if ({jumpEnabled, requestReady} !== 2'b01) begin
            tests_failed++;
            $display("FAIL not_taken_0: en=%b rdy=%b, required 0 1", jumpEnabled, requestReady);
        end
        step();
        step();
        tests_run++;
        if ({jumpEnabled, requestReady, flush} !== 3'b010) begin
            tests_failed++;
            $display("FAIL not_taken_1: en=%b rdy=%b flush=%b, required 0 1 0", jumpEnabled, requestReady, flush);
        end
        $display("[TB] not taken en=%b rdy=%b", jumpEnabled, requestReady);
    endtask

    task automatic test_bad_type();
        send(T_BAD, 32'h0000_6000, 32'h0000_0040, 1'b1);
        tests_run++;
        if ({badType, jumpEnabled, requestReady} !== 3'b101) begin
            tests_failed++;
            $display("FAIL bad_type_set: bad=%b en=%b rdy=%b, required 1 0 1", badType, jumpEnabled, requestReady);
        end
        step();
        step();
        tests_run++;
        if ({badType, jumpEnabled} !== 2'b10) begin
            tests_failed++;
            $display("FAIL bad_type_no_redirect: bad=%b en=%b, required 1 0", badType, jumpEnabled);
        end
        send(T_FAR, 32'h0, 32'h0000_8000, 1'b1);
        wait_issue();
        tests_run++;
        if ({badType, jumpEnabled, jumpValue} !== {1'b1, 1'b1, 32'h0000_8000}) begin
            tests_failed++;
            $display("FAIL bad_type_sticky: bad=%b en=%b val=%h, required 1 1 00008000",
                     badType, jumpEnabled, jumpValue);
        end
        step();
        $display("[TB] bad type bad=%b", badType);
    endtask

    task automatic test_async_reset();
        send(T_FAR, 32'h0, 32'h1234_5678, 1'b1);
        wait_issue();
        stall = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({jumpEnabled, jumpValue, flush, badType, requestReady} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL async_reset: en=%b val=%h flush=%b bad=%b rdy=%b, required 0 00000000 0 0 1",
                     jumpEnabled, jumpValue, flush, badType, requestReady);
        end
        @(negedge clock);
        reset = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (jumpEnabled !== 1'b0) begin
                tests_failed++;
                $display("FAIL async_reset_after_%0d: en=%b required 0", i, jumpEnabled);
            end
        end
        $display("[TB] async reset mid-issue");
    endtask

    task automatic test_timing();
`ifdef JUMP_DELAY_SLOT_EN
        send(T_FAR, 32'h0, 32'h0000_A000, 1'b1);
        tests_run++;
        if ({jumpEnabled, requestReady} !== 2'b00) begin
            tests_failed++;
            $display("FAIL slot_cycle: en=%b rdy=%b, required 0 0", jumpEnabled, requestReady);
        end
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if (jumpEnabled !== 1'b0) begin
                tests_failed++;
                $display("FAIL slot_stall_%0d: en=%b required 0", i, jumpEnabled);
            end
        end
        stall = 1'b0;
        step();
        tests_run++;
        if ({jumpEnabled, jumpValue} !== {1'b1, 32'h0000_A000}) begin
            tests_failed++;
            $display("FAIL slot_issue: en=%b val=%h, required 1 0000a000", jumpEnabled, jumpValue);
        end
        step();
        $display("[TB] delay slot timing");
`else
        send(T_FAR, 32'h0, 32'h0000_A000, 1'b1);
        tests_run++;
        if ({jumpEnabled, requestReady, jumpValue} !== {1'b1, 1'b0, 32'h0000_A000}) begin
            tests_failed++;
            $display("FAIL issue_next_cycle: en=%b rdy=%b val=%h, required 1 0 0000a000",
                     jumpEnabled, requestReady, jumpValue);
        end
        step();
        // Back-to-back: a new request accepted immediately on return to IDLE.
        send(T_NEAR, 32'h4000_1000, 32'h0000_0001, 1'b1);
        tests_run++;
        if ({jumpEnabled, jumpValue} !== {1'b1, 32'h4000_0004}) begin
            tests_failed++;
            $display("FAIL back_to_back: en=%b val=%h, required 1 40000004", jumpEnabled, jumpValue);
        end
        step();
        $display("[TB] no-slot timing");
`endif
    endtask

    initial begin
        test_reset();
        test_relative();
        test_targets();
        test_stall();
        test_hold_while_busy();
        test_not_taken();
        test_timing();
        test_bad_type();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
